// File: rtl/pos_scanner.sv
// Cursor over N_POS cells at STEP_DIV cycles per step; captures the cell on select, holds until ack.
// `define POS_SCAN_SKIP_EN makes each advance skip occupied cells; otherwise the cursor steps sequentially.
module pos_scanner #(
  parameter int N_POS    = 9,
  parameter int PW       = 4,
  parameter int STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             select,
  input  logic             ack,
  input  logic [N_POS-1:0] occupied,
  output logic [PW-1:0]    pos,
  output logic [PW-1:0]    chosen,
  output logic             ready,
  output logic             full
);

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [15:0]   DIV_LAST = 16'(STEP_DIV - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(N_POS - 1);

  state_t            state_q, state_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [PW-1:0]     chosen_q, chosen_d;
  logic              ready_q, ready_d;
  logic [15:0]       div_q, div_d;

  logic [(1<<PW)-1:0] occ_ext;
  logic [PW-1:0]      adv_pos;

  assign full = &occupied;

  // Cells beyond N_POS read as taken so any pos index is safe.
  always_comb begin
    occ_ext = '1;
    for (int i = 0; i < N_POS; i++) begin
      occ_ext[i] = occupied[i];
    end
  end

`ifdef POS_SCAN_SKIP_EN
  logic [PW:0] cand;
  logic        found;

  // First free cell after pos in wrap order; pos itself is never a candidate.
  always_comb begin
    adv_pos = pos_q;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k < N_POS; k++) begin
      cand = {1'b0, pos_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(N_POS)) begin
        cand = cand - (PW+1)'(N_POS);
      end
      if (!found && !occ_ext[cand[PW-1:0]]) begin
        found   = 1'b1;
        adv_pos = cand[PW-1:0];
      end
    end
  end
`else
  always_comb begin
    adv_pos = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
  end
`endif

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    chosen_d = chosen_q;
    ready_d  = ready_q;
    div_d    = div_q;
    case (state_q)
      SCAN: begin
        // While every cell is taken both cursor and divider stand still.
        if (!full) begin
          if (select && !occ_ext[pos_q]) begin
            state_d  = HOLD;
            chosen_d = pos_q;
            ready_d  = 1'b1;
          end else if (div_q == DIV_LAST) begin
            div_d = '0;
            pos_d = adv_pos;
          end else begin
            div_d = div_q + 16'd1;
          end
        end
      end
      HOLD: begin
        if (ack) begin
          state_d = SCAN;
          ready_d = 1'b0;
          div_d   = '0;
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= SCAN;
      pos_q    <= '0;
      chosen_q <= '0;
      ready_q  <= 1'b0;
      div_q    <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      chosen_q <= chosen_d;
      ready_q  <= ready_d;
      div_q    <= div_d;
    end
  end

  assign pos    = pos_q;
  assign chosen = chosen_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_pos_scanner.sv
// Directed bench: two scanners (STEP_DIV=1 and STEP_DIV=4) with hand-computed expected values.
module tb_pos_scanner;

  logic       clk = 1'b0;
  logic       rst1, sel1, ack1;
  logic [8:0] occ1;
  logic [3:0] pos1, chosen1;
  logic       ready1, full1;

  logic       rst4, sel4, ack4;
  logic [8:0] occ4;
  logic [3:0] pos4, chosen4;
  logic       ready4, full4;

  int chk_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  pos_scanner #(.N_POS(9), .PW(4), .STEP_DIV(1)) u_dut1 (
    .clk(clk), .reset(rst1), .select(sel1), .ack(ack1), .occupied(occ1),
    .pos(pos1), .chosen(chosen1), .ready(ready1), .full(full1)
  );

  pos_scanner #(.N_POS(9), .PW(4), .STEP_DIV(4)) u_dut4 (
    .clk(clk), .reset(rst4), .select(sel4), .ack(ack4), .occupied(occ4),
    .pos(pos4), .chosen(chosen4), .ready(ready4), .full(full4)
  );

  task automatic check(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq [7];
    int frz_pos;
    int n;

    rst1 = 1'b0; sel1 = 1'b0; ack1 = 1'b0; occ1 = '0;
    rst4 = 1'b0; sel4 = 1'b0; ack4 = 1'b0; occ4 = '0;

    // Reset and wrap
    tick(); tick();
    check("rst_pos", pos1, 0);
    check("rst_ready", ready1, 0);
    check("rst_chosen", chosen1, 0);
    check("rst_full", full1, 0);
    rst1 = 1'b1;
    for (int i = 0; i < 11; i++) begin
      check($sformatf("wrap_pos%0d", i), pos1, i % 9);
      check($sformatf("wrap_rdy%0d", i), ready1, 0);
      tick();
    end
    check("wrap_end", pos1, 2);

    // Capture and ack at pos 5
    tick(); tick(); tick();
    check("pre_cap_pos", pos1, 5);
    sel1 = 1'b1;
    tick();
    sel1 = 1'b0;
    check("cap_ready", ready1, 1);
    check("cap_chosen", chosen1, 5);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("hold_pos%0d", i), pos1, 5);
      check($sformatf("hold_rdy%0d", i), ready1, 1);
    end
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    check("ack_ready", ready1, 0);
    check("ack_pos", pos1, 5);
    tick();
    check("post_ack_pos", pos1, 6);

    // Occupied cells 2,3,4
    occ1 = 9'b000011100;
`ifdef POS_SCAN_SKIP_EN
    tick(); tick(); tick(); tick();
    seq = '{1, 5, 6, 7, 8, 0, 1};
    for (int i = 0; i < 7; i++) begin
      check($sformatf("skip_pos%0d", i), pos1, seq[i]);
      tick();
    end
    check("skip_end", pos1, 5);
    frz_pos = 5;
`else
    seq = '{7, 8, 0, 1, 2, 3, 3};
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("seq_pos%0d", i), pos1, seq[i]);
    end
    sel1 = 1'b1;
    tick();
    sel1 = 1'b0;
    check("occ_refuse_rdy", ready1, 0);
    check("occ_refuse_pos", pos1, 4);
    frz_pos = 4;
`endif

    // Full board: cursor frozen, select ignored
    occ1 = 9'h1FF;
    #1;
    check("full_flag", full1, 1);
    sel1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("full_pos%0d", i), pos1, frz_pos);
      check($sformatf("full_rdy%0d", i), ready1, 0);
    end
    sel1 = 1'b0;
    occ1 = '0;
    #1;
    check("unfull_flag", full1, 0);

    // Select together with ack in HOLD
    sel1 = 1'b1;
    tick();
    check("sim_cap_rdy", ready1, 1);
    check("sim_cap_chosen", chosen1, frz_pos);
    ack1 = 1'b1;
    tick();
    sel1 = 1'b0; ack1 = 1'b0;
    check("sim_ready", ready1, 0);
    check("sim_pos", pos1, frz_pos);
    tick();
    check("sim_adv", pos1, frz_pos + 1);
    check("sim_no_recap", ready1, 0);

    // Reset in the middle of HOLD
    n = 0;
    while (pos1 !== 4'd7 && n < 20) begin
      tick();
      n++;
    end
    check("reach7", pos1, 7);
    sel1 = 1'b1;
    tick();
    sel1 = 1'b0;
    check("h7_ready", ready1, 1);
    check("h7_chosen", chosen1, 7);
    rst1 = 1'b0;
    tick();
    rst1 = 1'b1;
    check("mrst_ready", ready1, 0);
    check("mrst_chosen", chosen1, 0);
    check("mrst_pos", pos1, 0);
    tick();
    check("mrst_scan", pos1, 1);

    // Divider of 4
    tick();
    rst4 = 1'b1;
    check("d4_rst_pos", pos4, 0);
    for (int t = 1; t <= 11; t++) begin
      tick();
      check($sformatf("d4_pos_t%0d", t), pos4, t / 4);
    end
    sel4 = 1'b1;
    tick();
    sel4 = 1'b0;
    check("d4_cap_rdy", ready4, 1);
    check("d4_cap_chosen", chosen4, 2);
    check("d4_cap_pos", pos4, 2);
    tick();
    check("d4_hold_pos", pos4, 2);
    ack4 = 1'b1;
    tick();
    ack4 = 1'b0;
    check("d4_ack_rdy", ready4, 0);
    for (int t = 1; t <= 3; t++) begin
      tick();
      check($sformatf("d4_post_ack%0d", t), pos4, 2);
    end
    tick();
    check("d4_first_adv", pos4, 3);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pos_scanner.md
# pos_scanner

Parametrised position scanner for the board-game controller. A cursor steps through `N_POS` cell positions at a programmable rate, wrapping at the end. With skipping enabled it passes over occupied cells. On `select` it captures the current cell and raises `ready`, then holds until the controller FSM acknowledges with `ack`. It sits between the player push-button synchroniser and the game-control FSM, which consumes `chosen`, updates `occupied`, and pulses `ack`.

## Interface
- `N_POS`, 9: number of cell positions, legal range 2..16.
- `PW`, 4: position width; must satisfy 2^PW >= N_POS.
- `STEP_DIV`, 1: clock cycles per cursor advance, range 1..2^16-1.

Ports:
- `clk` input 1: system clock, all logic on its rising edge.
- `reset` input 1: synchronous, active-low reset.
- `select` input 1: player selects current cursor cell; level, sampled each cycle.
- `ack` input 1: FSM has consumed `chosen`; level, sampled each cycle.
- `occupied` input N_POS: bit i=1 marks cell i taken.
- `pos` output PW: current cursor position, 0..N_POS-1.
- `chosen` output PW: captured position, valid while `ready`=1.
- `ready` output 1: capture pending.
- `full` output 1: combinational; 1 when every bit of `occupied` is 1.

## Operation
- Reset (`reset`=0 at a rising edge) sets `pos`=0, `chosen`=0, `ready`=0, state=SCAN and divider=0. Reset wins over every other input, including in the middle of a HOLD.
- States:
  - SCAN: the divider counts 0..STEP_DIV-1. When divider==STEP_DIV-1, `pos` advances and the divider returns to 0.
  - HOLD: `pos` and the divider are frozen, and `ready`=1.
- Advance target: the next position after `pos` in wrap order (N_POS-1 goes to 0).
  - With skipping compiled in, the target is the first unoccupied cell searched from pos+1 with wrap, up to N_POS-1 candidates.
  - If no other cell is free, `pos` holds.
- SCAN to HOLD: requires `select`=1 and `occupied[pos]`=0 and `full`=0.
  - `chosen`<=`pos` (the registered value that cycle) and `ready`<=1.
  - The advance scheduled for that same cycle is suppressed.
- `select` is ignored in these cases:
  - the current cell is occupied;
  - `full`=1 (the cursor also freezes while full);
  - the block is in HOLD.
- HOLD to SCAN: requires `ack`=1. Then `ready`<=0 and the divider<=0, and `pos` is unchanged.
- In HOLD, `select` and `ack` asserted together: `ack` is honoured and `select` is dropped; no re-capture on that edge.
- `ack` in SCAN: no effect.
- Changes on `occupied` during HOLD do not alter `chosen`. In SCAN they take effect at the next advance.

## Timing
- `select` sampled at edge n gives `ready`=1 and valid `chosen` after edge n (1-cycle latency).
- `ack` sampled at edge m gives `ready`=0 after edge m. The first advance comes STEP_DIV edges after m.
- A held `select` re-captures on the first SCAN cycle after the release edge. The FSM must deassert `select` (edge-detect upstream) if it needs one capture per press.
- Cursor period is exactly STEP_DIV cycles per step; skipped cells add no cycles.
- `full` is combinational from `occupied`; everything else is registered.

## Configuration
- `POS_SCAN_SKIP_EN` defined: the advance skips occupied cells as described above.
- `POS_SCAN_SKIP_EN` undefined:
  - `pos` steps sequentially 0,1,…,N_POS-1,0 regardless of `occupied`.
  - Capture on an occupied cell is still refused.
  - `full` still freezes the cursor and blocks capture.

## Test plan
- Reset and wrap (N_POS=9, STEP_DIV=1, occupied=0): hold `reset`=0 for 2 cycles, then release. `pos` must read 0,1,…,8,0,1 on consecutive cycles, with `ready`=0 throughout.
- Capture/ack: `select`=1 for one cycle while `pos`=5. Next cycle `ready`=1 and `chosen`=5, and `pos` stays 5 for 10 idle cycles. Pulse `ack`: `ready`=0 on the next cycle and `pos`=6 one cycle later.
- Skip (macro defined): `occupied`=9'b000011100 with `pos`=1 gives the sequence 1,5,6,7,8,0,1.
  - With the macro undefined, `select` at `pos`=3 leaves `ready`=0.
- Divider (STEP_DIV=4): `pos` changes exactly every 4 cycles. A `select` on the advance cycle at `pos`=2 captures `chosen`=2, and `pos` stays 2.
- Full and simultaneous: `occupied`=9'h1FF gives `full`=1, `pos` frozen, and `select` ignored. In HOLD, `select`=1 together with `ack`=1 gives `ready`=0 on the next cycle and no re-capture.
- Reset mid-HOLD: with `ready`=1 and `chosen`=7, `reset`=0 for one edge gives `ready`=0, `chosen`=0, `pos`=0 and state SCAN.
